// File: rtl/wb_slave_mem_responder.sv
// Wishbone B3 slave memory answering the MAC's DMA master port.
// Classic single transfers and linear incrementing bursts, programmable
// wait states before the first beat, ERR for out-of-range or unsupported
// accesses, and saturating per-direction beat counters.
// Ports:
//   wb_clk_i, wb_rst_n_i          clock, async active-low reset
//   wb_adr_i/dat_i/sel_i/we_i     request address, write data, lanes, direction
//   wb_cyc_i/stb_i/cti_i/bte_i    cycle, strobe, cycle type, burst type
//   wb_dat_o/ack_o/err_o          read data and terminations
//   wait_cfg_i                    wait states before the first beat
//   wr_beats_o/rd_beats_o         acked write/read beat counts (saturating)
module wb_slave_mem_responder #(
    parameter int unsigned             ADDR_WIDTH = 32,
    parameter int unsigned             DATA_WIDTH = 32,
    parameter int unsigned             MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = '0
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_n_i,
    input  logic [ADDR_WIDTH-1:0]     wb_adr_i,
    input  logic [DATA_WIDTH-1:0]     wb_dat_i,
    output logic [DATA_WIDTH-1:0]     wb_dat_o,
    input  logic [DATA_WIDTH/8-1:0]   wb_sel_i,
    input  logic                      wb_we_i,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    input  logic [2:0]                wb_cti_i,
    input  logic [1:0]                wb_bte_i,
    output logic                      wb_ack_o,
    output logic                      wb_err_o,
    input  logic [3:0]                wait_cfg_i,
    output logic [15:0]               wr_beats_o,
    output logic [15:0]               rd_beats_o
);

    localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned IDX_WIDTH = $clog2(MEM_DEPTH);
    // One extra bit so a burst can step exactly one word past the top.
    localparam int unsigned PTR_WIDTH = IDX_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [PTR_WIDTH-1:0]  DEPTH_P = PTR_WIDTH'(MEM_DEPTH);
    localparam logic [2:0] CTI_INCR = 3'b010;
    localparam logic [2:0] CTI_EOB  = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_BURST} state_t;

    state_t                 state_q;
    logic [PTR_WIDTH-1:0]   addr_q;
    logic [3:0]             wcnt_q;
    logic                   we_q;
    logic                   err_q;
    logic                   burst_q;
    logic [15:0]            wr_cnt_q;
    logic [15:0]            rd_cnt_q;
    logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];

    logic                   borrow;
    logic [ADDR_WIDTH-1:0]  adr_off;
    logic [ADDR_WIDTH-1:0]  word;
    logic                   req_err;
    logic                   beat;
    logic                   term_phase;
    logic                   beat_err;

    // Request decode: borrow marks an address below the window.
    assign {borrow, adr_off} = {1'b0, wb_adr_i} - {1'b0, BASE_ADDR};
    assign word    = adr_off >> 2;
    assign req_err = borrow || (word >= DEPTH_A) ||
                     ((wb_cti_i == CTI_INCR) && (wb_bte_i != 2'b00));

    // First beat uses the flag captured at request; later beats check the pointer.
    assign beat       = wb_cyc_i && wb_stb_i;
    assign term_phase = (state_q == S_RESP) || (state_q == S_BURST);
    assign beat_err   = (state_q == S_RESP) ? err_q : (addr_q >= DEPTH_P);
    assign wb_ack_o   = beat && term_phase && !beat_err;
    assign wb_err_o   = beat && term_phase && beat_err;
    assign wb_dat_o   = wb_ack_o ? mem[addr_q[IDX_WIDTH-1:0]] : '0;

    // Transfer FSM and captured request attributes.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wcnt_q  <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            burst_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (beat) begin
                        addr_q  <= PTR_WIDTH'(word);
                        we_q    <= wb_we_i;
                        err_q   <= req_err;
                        burst_q <= (wb_cti_i == CTI_INCR);
                        wcnt_q  <= wait_cfg_i;
                        state_q <= (wait_cfg_i != 4'd0) ? S_WAIT : S_RESP;
                    end
                end
                S_WAIT: begin
                    if (!wb_cyc_i) begin
                        wcnt_q  <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        wcnt_q <= wcnt_q - 4'd1;
                        if (wcnt_q == 4'd1) begin
                            state_q <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (!wb_cyc_i || wb_err_o) begin
                        state_q <= S_IDLE;
                    end else if (wb_ack_o) begin
                        addr_q  <= addr_q + PTR_WIDTH'(1);
                        state_q <= burst_q ? S_BURST : S_IDLE;
                    end
                end
                S_BURST: begin
                    if (!wb_cyc_i || wb_err_o) begin
                        state_q <= S_IDLE;
                    end else if (wb_ack_o) begin
                        addr_q <= addr_q + PTR_WIDTH'(1);
                        if (wb_cti_i == CTI_EOB) begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Byte-lane writes on acked write beats; contents survive reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_ack_o && we_q) begin
            for (int unsigned b = 0; b < SEL_WIDTH; b++) begin
                if (wb_sel_i[b]) begin
                    mem[addr_q[IDX_WIDTH-1:0]][b*8 +: 8] <= wb_dat_i[b*8 +: 8];
                end
            end
        end
    end

    // Saturating beat counters.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else if (wb_ack_o) begin
            if (we_q) begin
                if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
            end else begin
                if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
            end
        end
    end

    assign wr_beats_o = wr_cnt_q;
    assign rd_beats_o = rd_cnt_q;

endmodule

// File: tb/tb_wb_slave_mem_responder.sv
// Self-checking bench for wb_slave_mem_responder: directed cases plus
// randomized classic/burst traffic against a word-array reference model.
module tb_wb_slave_mem_responder;

    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] adr = '0;
    logic [31:0] wdat = '0;
    logic [31:0] rdat;
    logic [3:0]  sel = '0;
    logic        we = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic [2:0]  cti = '0;
    logic [1:0]  bte = '0;
    logic        ack;
    logic        err;
    logic [3:0]  wait_cfg = '0;
    logic [15:0] wr_beats;
    logic [15:0] rd_beats;

    always #5 clk = ~clk;

    wb_slave_mem_responder #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_DEPTH  (DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wb_adr_i   (adr),
        .wb_dat_i   (wdat),
        .wb_dat_o   (rdat),
        .wb_sel_i   (sel),
        .wb_we_i    (we),
        .wb_cyc_i   (cyc),
        .wb_stb_i   (stb),
        .wb_cti_i   (cti),
        .wb_bte_i   (bte),
        .wb_ack_o   (ack),
        .wb_err_o   (err),
        .wait_cfg_i (wait_cfg),
        .wr_beats_o (wr_beats),
        .rd_beats_o (rd_beats)
    );

    logic [31:0] model_mem [DEPTH];
    int          model_wr = 0;
    int          model_rd = 0;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_rd = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_wr_beats"}, {16'h0, wr_beats}, 32'(model_wr));
        check({tag, "_rd_beats"}, {16'h0, rd_beats}, 32'(model_rd));
    endtask

    // One Wishbone transaction of n beats (classic when burst=0).
    task automatic xfer(input logic [31:0] a, input logic w_en, input int n, input logic burst,
                        input logic [1:0] bt, input logic [3:0] w, input logic stall_en,
                        input logic fixed, input logic [31:0] d0,
                        input logic rand_sel, input logic [3:0] sel0);
        longint      off;
        logic        rq_err;
        int          word0;
        int          lat;
        logic        done;
        logic        stop;
        logic        exp_err;
        logic        got_err;
        logic [31:0] wd;
        logic [3:0]  sl;
        off    = longint'(a) - longint'(BASE);
        rq_err = (off < 0) || ((off >>> 2) >= longint'(DEPTH)) || (burst && bt != 2'b00);
        word0  = rq_err ? 0 : int'(off >>> 2);
        stop   = 1'b0;
        @(posedge clk); #1;
        for (int b = 0; b < n && !stop; b++) begin
            wd = fixed ? d0 + 32'(b) : $urandom;
            sl = rand_sel ? 4'($urandom) : sel0;
            if (b > 0 && stall_en && $urandom_range(0, 1) == 1) begin
                stb = 1'b0;
                @(negedge clk);
                check("stall_term", {30'h0, ack, err}, 32'h0);
                @(posedge clk); #1;
            end
            cyc  = 1'b1;
            stb  = 1'b1;
            we   = w_en;
            adr  = a + 32'(4 * b);
            wdat = wd;
            sel  = sl;
            cti  = !burst ? 3'b000 : (b == n - 1) ? 3'b111 : 3'b010;
            bte  = bt;
            if (b == 0) begin
                wait_cfg = w;
                @(posedge clk);
            end
            lat  = 0;
            done = 1'b0;
            for (int i = 1; i <= 40 && !done; i++) begin
                @(negedge clk);
                if (b == 0 && i == 1) wait_cfg = 4'($urandom);
                if (ack || err) begin
                    lat  = i;
                    done = 1'b1;
                end
            end
            if (!done) begin
                check("timeout", 32'h0, 32'h1);
                stop = 1'b1;
            end else begin
                exp_err = (b == 0) ? rq_err : ((word0 + b) >= int'(DEPTH));
                got_err = err;
                check("latency", 32'(lat), (b == 0) ? 32'(w) + 32'd1 : 32'd1);
                check("ack_and_err", {31'h0, ack & err}, 32'h0);
                check("err_term", {31'h0, got_err}, {31'h0, exp_err});
                if (got_err) check("err_dat", rdat, 32'h0);
                if (!exp_err) begin
                    if (w_en) begin
                        for (int l = 0; l < 4; l++)
                            if (sl[l]) model_mem[word0 + b][l*8 +: 8] = wd[l*8 +: 8];
                        model_wr++;
                    end else begin
                        check("rdata", rdat, model_mem[word0 + b]);
                        last_rd = rdat;
                        model_rd++;
                    end
                end
                if (got_err || exp_err) stop = 1'b1;
                @(posedge clk); #1;
            end
        end
        cyc = 1'b0;
        stb = 1'b0;
        cti = 3'b000;
        bte = 2'b00;
        check_counters("xfer");
    endtask

    initial begin
        // Reset state.
        #1 rst_n = 1'b0;
        #20;
        check("rst_ack", {31'h0, ack}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_dat", rdat, 32'h0);
        check_counters("rst");
        @(posedge clk); #1 rst_n = 1'b1;

        // Classic write then read at W=0.
        xfer(BASE + 32'h10, 1'b1, 1, 1'b0, 2'b00, 4'd0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 4'hF);
        xfer(BASE + 32'h10, 1'b0, 1, 1'b0, 2'b00, 4'd0, 1'b0, 1'b1, 32'h0, 1'b0, 4'hF);
        check("classic_rd", last_rd, 32'hDEADBEEF);
        check("classic_wr_cnt", {16'h0, wr_beats}, 32'd1);
        check("classic_rd_cnt", {16'h0, rd_beats}, 32'd1);

        // Byte lanes with three wait states.
        xfer(BASE + 32'h20, 1'b1, 1, 1'b0, 2'b00, 4'd0, 1'b0, 1'b1, 32'hAABBCCDD, 1'b0, 4'hF);
        xfer(BASE + 32'h20, 1'b1, 1, 1'b0, 2'b00, 4'd3, 1'b0, 1'b1, 32'h11223344, 1'b0, 4'b0101);
        xfer(BASE + 32'h20, 1'b0, 1, 1'b0, 2'b00, 4'd0, 1'b0, 1'b1, 32'h0, 1'b0, 4'hF);
        check("lanes_rd", last_rd, 32'hAA22CC44);

        // Four-beat incrementing burst write and read-back.
        xfer(BASE, 1'b1, 4, 1'b1, 2'b00, 4'd0, 1'b0, 1'b1, 32'd1, 1'b0, 4'hF);
        xfer(BASE, 1'b0, 4, 1'b1, 2'b00, 4'd0, 1'b0, 1'b1, 32'h0, 1'b0, 4'hF);
        check("burst_last_rd", last_rd, 32'd4);

        // Error terminations: word DEPTH, and an unsupported burst type.
        xfer(BASE + 32'(4 * DEPTH), 1'b1, 1, 1'b0, 2'b00, 4'd1, 1'b0, 1'b1, 32'h0BAD0BAD, 1'b0, 4'hF);
        xfer(BASE, 1'b1, 3, 1'b1, 2'b01, 4'd0, 1'b0, 1'b1, 32'hFFFF0000, 1'b0, 4'hF);
        xfer(BASE, 1'b0, 1, 1'b0, 2'b00, 4'd0, 1'b0, 1'b1, 32'h0, 1'b0, 4'hF);
        check("bte_no_write", last_rd, 32'd1);
        xfer(BASE - 32'd4, 1'b0, 1, 1'b0, 2'b00, 4'd0, 1'b0, 1'b1, 32'h0, 1'b0, 4'hF);

        // Burst running off the top of memory: ack, ack, err.
        xfer(BASE + 32'(4 * (DEPTH - 2)), 1'b1, 4, 1'b1, 2'b00, 4'd2, 1'b0, 1'b1, 32'h100, 1'b0, 4'hF);

        // Fill the whole memory so random reads are defined.
        xfer(BASE, 1'b1, DEPTH, 1'b1, 2'b00, 4'd0, 1'b0, 1'b0, 32'h0, 1'b0, 4'hF);

        // Reset while waiting: W=5, reset at the second wait cycle.
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h40; wdat = 32'h5555AAAA;
        sel = 4'hF; cti = 3'b000; bte = 2'b00; wait_cfg = 4'd5;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstwait_ack", {31'h0, ack}, 32'h0);
        check("rstwait_err", {31'h0, err}, 32'h0);
        check("rstwait_dat", rdat, 32'h0);
        model_wr = 0;
        model_rd = 0;
        check_counters("rstwait");
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;

        // Reset while ack is being driven must kill it and suppress the write.
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h80; wdat = 32'hCAFEF00D;
        sel = 4'hF; cti = 3'b000; bte = 2'b00; wait_cfg = 4'd0;
        @(posedge clk);
        @(negedge clk);
        check("rstresp_ack_pre", {31'h0, ack}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rstresp_ack", {31'h0, ack}, 32'h0);
        check("rstresp_err", {31'h0, err}, 32'h0);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        rst_n = 1'b1;
        check_counters("rstresp");

        // Normal operation after reset; neither aborted write landed.
        xfer(BASE + 32'h40, 1'b0, 1, 1'b0, 2'b00, 4'd0, 1'b0, 1'b1, 32'h0, 1'b0, 4'hF);
        xfer(BASE + 32'h80, 1'b0, 1, 1'b0, 2'b00, 4'd2, 1'b0, 1'b1, 32'h0, 1'b0, 4'hF);

        // Randomized classic and burst traffic.
        for (int t = 0; t < 120; t++) begin
            logic [31:0] ra;
            logic        rburst;
            int          rn;
            logic [1:0]  rbte;
            if ($urandom_range(0, 9) == 0)
                ra = BASE - 32'(4 * $urandom_range(1, 4));
            else
                ra = BASE + 32'(4 * $urandom_range(0, DEPTH + 3)) + 32'($urandom_range(0, 3));
            rburst = 1'($urandom_range(0, 1));
            rn     = rburst ? $urandom_range(1, 6) : 1;
            rbte   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            xfer(ra, 1'($urandom_range(0, 1)), rn, rburst, rbte, 4'($urandom_range(0, 3)),
                 1'b1, 1'b0, 32'h0, 1'b1, 4'hF);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
